// File: rtl/shift_register_tx.sv
// Parallel-in, serial-out transmitter: takes a w-bit word over valid/ready and
// emits it LSB first, one bit per en strobe, with back-to-back reload on the last bit.
module shift_register_tx #(
    parameter int unsigned w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load_valid,
    input  logic [w-1:0] load_data,
    output logic         load_ready,
    output logic         out,
    output logic         out_valid,
    output logic         busy,
    output logic         done
);
    localparam int unsigned CW = (w > 1) ? $clog2(w) : 1;
    localparam logic [CW-1:0] LAST = CW'(w - 1);

    typedef enum logic {Idle, Shift} state_t;

    state_t        state;
    logic [w-1:0]  sr;
    logic [CW-1:0] cnt;
    logic          last_bit;

    // The final strobe of a word frees the register in the same cycle.
    assign last_bit   = (state == Shift) && en && (cnt == LAST);
    assign load_ready = (state == Idle) || last_bit;

    assign out       = (state == Shift) && sr[0];
    assign out_valid = (state == Shift);
    assign busy      = (state == Shift);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= Idle;
            sr    <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= last_bit;
            case (state)
                Idle: begin
                    if (load_valid) begin
                        sr    <= load_data;
                        cnt   <= '0;
                        state <= Shift;
                    end
                end
                Shift: begin
                    if (en) begin
                        if (cnt != LAST) begin
                            sr  <= sr >> 1;
                            cnt <= cnt + CW'(1);
                        end else if (load_valid) begin
                            sr  <= load_data;
                            cnt <= '0;
                        end else begin
                            sr    <= '0;
                            cnt   <= '0;
                            state <= Idle;
                        end
                    end
                end
                default: state <= Idle;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_register_tx.sv
// Bench for shift_register_tx: directed and random stimulus against a bit-queue model,
// plus a bench-side receiver for loopback and a w=1 instance.
module tb_shift_register_tx;
    logic       clk = 1'b0;
    logic       rst, en, load_valid;
    logic [7:0] load_data;
    logic       load_ready, out, out_valid, busy, done;

    logic       rst1, en1, lv1;
    logic [0:0] ld1;
    logic       lr1, o1, ov1, b1, d1;

    bit         q[$];
    bit         ql[$];
    logic       done_e;
    logic [7:0] rx;
    logic [7:0] word;
    int         nvec = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    shift_register_tx #(.w(8)) dut (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .out(out), .out_valid(out_valid), .busy(busy), .done(done)
    );

    shift_register_tx #(.w(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .load_valid(lv1), .load_data(ld1),
        .load_ready(lr1), .out(o1), .out_valid(ov1), .busy(b1), .done(d1)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: a word accepted pushes its w bits; each strobe while busy pops one.
    task automatic cycle(input logic v, input logic e, input logic [7:0] d, input logic r);
        logic ready_e, acc, pop, o_pre, ov_pre;
        load_valid = v;
        en         = e;
        load_data  = d;
        rst        = r;
        #1;
        ready_e = (q.size() == 0) || (q.size() == 1 && e);
        chk("load_ready", {7'b0, load_ready}, {7'b0, ready_e});
        o_pre  = out;
        ov_pre = out_valid;
        @(posedge clk);
        if (r) begin
            q.delete();
            ql.delete();
            done_e = 1'b0;
        end else begin
            acc    = v && ready_e;
            pop    = e && (q.size() > 0);
            done_e = pop ? ql[0] : 1'b0;
            if (pop) begin
                void'(q.pop_front());
                void'(ql.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < 8; i++) begin
                    q.push_back(d[i]);
                    ql.push_back(i == 7);
                end
            end
            if (e && ov_pre) rx = {o_pre, rx[7:1]};
        end
        #1;
        chk("out", {7'b0, out}, {7'b0, (q.size() > 0) ? q[0] : 1'b0});
        chk("out_valid", {7'b0, out_valid}, {7'b0, q.size() > 0});
        chk("busy", {7'b0, busy}, {7'b0, q.size() > 0});
        chk("done", {7'b0, done}, {7'b0, done_e});
    endtask

    task automatic cycle1(input logic v, input logic e, input logic d, input logic x_ready,
                          input logic x_out, input logic x_ov, input logic x_done);
        lv1 = v;
        en1 = e;
        ld1 = d;
        #1;
        chk("w1_load_ready", {7'b0, lr1}, {7'b0, x_ready});
        @(posedge clk);
        #1;
        chk("w1_out", {7'b0, o1}, {7'b0, x_out});
        chk("w1_out_valid", {7'b0, ov1}, {7'b0, x_ov});
        chk("w1_done", {7'b0, d1}, {7'b0, x_done});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load_valid = 1'b0; load_data = '0;
        rst1 = 1'b1; en1 = 1'b0; lv1 = 1'b0; ld1 = '0;
        done_e = 1'b0;
        rx = '0;
        @(posedge clk);
        #1;
        rst1 = 1'b0;

        // Reset state
        cycle(1'b1, 1'b1, 8'hFF, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // A5 with en tied high, then idle
        cycle(1'b1, 1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

        // Loopback with en every third cycle
        rx = '0;
        cycle(1'b1, 1'b0, 8'h3C, 1'b0);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, (i % 3) == 2, 8'h00, 1'b0);
            if (done_e) chk("loopback", rx, 8'h3C);
        end

        // Back-to-back 01 then 80
        cycle(1'b1, 1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 8'h80, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

        // Reset mid-word, then a full word
        cycle(1'b1, 1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b1);
        rx = '0;
        cycle(1'b1, 1'b1, 8'h0F, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            if (done_e) chk("after_reset_word", rx, 8'h0F);
        end

        // Stall with load_data churning
        word = 8'($urandom);
        rx = '0;
        cycle(1'b1, 1'b1, word, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            if (done_e) chk("stall_word", rx, word);
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  $urandom_range(0, 49) == 0);

        // w=1 instance: single-bit words, reload on the only strobe
        cycle1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
